imem_loader: RTL and testbench

Boot-time program loader that writes instruction memory, the write-side counterpart to the pipeline's instruction fetch. It accepts a byte stream over a valid/ready handshake, parses a length header, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at byte address 0. It holds the CPU in reset until the image is completely written (and, optionally, checksum-verified). It then releases the CPU to fetch from PC 0.

---
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory loader.
//
// Accepts a byte stream over valid/ready. The stream is a 16-bit big-endian
// word count N, then N big-endian 32-bit instruction words. Each word is
// written to instruction memory at consecutive word addresses starting at
// byte address 0. The CPU is held in reset (cpu_hold=1) until the whole image
// is written. It is then released to fetch from PC 0.
//
// Optional feature (macro IMEM_LOADER_CSUM_EN):
//   A trailing checksum byte follows the payload. It is the XOR of all
//   payload bytes. A match finishes the load; a mismatch is an error.
//
// Parameters:
//   ADDR_WIDTH  word-address width of imem (capacity 2^ADDR_WIDTH words, <=16)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   byte_valid  source presents byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (combinational)
//   reload      single-cycle pulse: abort/restart the load
//   imem_we     one-cycle write strobe per word
//   imem_waddr  word-aligned byte address of the write
//   imem_wdata  instruction word to write
//   cpu_hold    active-high CPU reset while loading / on error
//   done        image loaded successfully
//   err         load failed (length overflow or checksum mismatch)
//   word_cnt    words written in the current load
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] acc_q, acc_d;     // first three bytes of the word in flight
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [15:0] nlen;
  logic        full;
  logic        hs;

  assign nlen = {len_q[15:8], byte_data};

  // In DATA with every word already accepted, the final write is on the bus
  // this cycle. Stop taking bytes and move to DONE on the next edge. This
  // keeps DONE strictly after the final imem_we pulse.
  assign full = (state_q == DATA) && (cnt_q == len_q);

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO: byte_ready = 1'b1;
      DATA:           byte_ready = !full;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:           byte_ready = 1'b1;
`endif
      default:        byte_ready = 1'b0;
    endcase
    if (reload) byte_ready = 1'b0;
  end

  assign hs = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    if (reload) begin
      state_d = LEN_HI;
      cnt_d   = '0;
      bidx_d  = '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        LEN_HI: if (hs) begin
          len_d[15:8] = byte_data;
          state_d     = LEN_LO;
        end
        LEN_LO: if (hs) begin
          len_d  = nlen;
          bidx_d = '0;
          if ({1'b0, nlen} > CAP)
            state_d = ERR;
          else if (nlen == 16'd0)
`ifdef IMEM_LOADER_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          else
            state_d = DATA;
        end
        DATA: begin
          if (hs) begin
            bidx_d = bidx_q + 2'd1;
            acc_d  = {acc_q[15:0], byte_data};
`ifdef IMEM_LOADER_CSUM_EN
            csum_d = csum_q ^ byte_data;
`endif
            if (bidx_q == 2'd3) begin
              we_d    = 1'b1;
              wdata_d = {acc_q, byte_data};
              waddr_d = 32'({cnt_q, 2'b00});
              cnt_d   = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
              // The checksum byte cannot be accepted before the next edge,
              // so it always lands after the final write.
              if (cnt_q + 16'd1 == len_q) state_d = CSUM;
`endif
            end
          end else if (full) begin
            state_d = DONE;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        CSUM: if (hs) state_d = (byte_data == csum_q) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LEN_HI;
      len_q   <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt   = cnt_q;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader. The model builds each byte stream from
// an image (a list of words) and predicts the outcome from the loader's
// rules: which writes happen, the final done/err/cpu_hold/word_cnt, and the
// number of cycles from the last handshake to done/err.
module tb_imem_loader;
  localparam int AW = 8;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        reload = 1'b0;
  logic        byte_ready, imem_we, cpu_hold, done, err;
  logic [31:0] imem_waddr, imem_wdata;
  logic [15:0] word_cnt;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          gap_max = 2;
  logic [7:0]  stream_q[$];
  logic [31:0] img[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Capture every write strobe seen mid-cycle.
  always @(negedge clk) if (imem_we) begin
    wa_q.push_back(imem_waddr);
    wd_q.push_back(imem_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Present stream_q bytes with random idle gaps; each byte is held until taken.
  task automatic send_stream();
    int t;
    int stalls;
    stalls = 0;
    for (int i = 0; i < stream_q.size(); i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stream_q[i];
      t = 0;
      #1;
      while (!byte_ready && t < 50) begin
        @(negedge clk); #1; t++;
      end
      stalls += t;
      if (t >= 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge clk);
    end
    if (gap_max == 0) chk("backtoback_stalls", stalls, 0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
    #1 chk("ready_on_reload", byte_ready, 1'b0);
    @(negedge clk);
    reload = 1'b0; byte_valid = 1'b0;
    chk("reload_wcnt", word_cnt, 0);
    chk("reload_hold", cpu_hold, 1'b1);
    chk("reload_done", done, 1'b0);
    chk("reload_err", err, 1'b0);
  endtask

  // Full load of n words from img; bad corrupts the checksum byte.
  task automatic run_load(input int n, input bit bad);
    logic [7:0]  x;
    logic [31:0] w;
    bit          ovf, exp_err;
    int          exp_lat, exp_wr, lat;
    stream_q.delete(); wa_q.delete(); wd_q.delete();
    x = 8'h00;
    ovf = (n > (1 << AW));
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    if (!ovf) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        for (int b = 3; b >= 0; b--) begin
          stream_q.push_back(w[8*b +: 8]);
          x ^= w[8*b +: 8];
        end
      end
      if (CSUM_ON) stream_q.push_back(bad ? (x ^ 8'h01) : x);
    end
    exp_err = ovf || (CSUM_ON && bad);
    exp_wr  = ovf ? 0 : n;
    exp_lat = (ovf || CSUM_ON || n == 0) ? 1 : 2;

    send_stream();
    lat = 0;
    do begin
      @(negedge clk);
      byte_valid = 1'b0;
      lat++;
    end while (!(done || err) && lat < 8);
    chk("end_latency", lat, exp_lat);
    chk("done", done, !exp_err);
    chk("err", err, exp_err);
    chk("cpu_hold", cpu_hold, exp_err);
    chk("word_cnt", word_cnt, exp_wr);

    // A byte offered after the load ends must be refused.
    byte_valid = 1'b1; byte_data = 8'h5A;
    #1 chk("ready_after_end", byte_ready, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("word_cnt_hold", word_cnt, exp_wr);

    chk("write_count", wa_q.size(), exp_wr);
    for (int i = 0; i < exp_wr && i < wa_q.size(); i++) begin
      chk("write_addr", wa_q[i], 32'(4 * i));
      chk("write_data", wd_q[i], img[i]);
    end
    do_reload();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_waddr", imem_waddr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_wcnt", word_cnt, 0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;

    img = {32'h3C080005, 32'h21090001};
    run_load(2, 1'b0);
    fill_img(0);
    run_load(0, 1'b0);
    run_load(257, 1'b0);
    gap_max = 0;
    fill_img(256);
    run_load(256, 1'b0);
    gap_max = 2;
    if (CSUM_ON) begin
      img = {32'h00000001};
      run_load(1, 1'b1);
    end

    // reload while word 3 is half received
    fill_img(4);
    stream_q.delete();
    stream_q.push_back(8'h00); stream_q.push_back(8'h04);
    for (int i = 0; i < 10; i++) stream_q.push_back(img[i / 4][8*(3 - i % 4) +: 8]);
    wa_q.delete(); wd_q.delete();
    send_stream();
    do_reload();
    chk("partial_writes", wa_q.size(), 2);
    run_load(4, 1'b0);

    // reset mid-DATA
    fill_img(3);
    stream_q.delete();
    stream_q.push_back(8'h00); stream_q.push_back(8'h03);
    for (int i = 0; i < 5; i++) stream_q.push_back(img[i / 4][8*(3 - i % 4) +: 8]);
    send_stream();
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_we", imem_we, 1'b0);
    chk("arst_waddr", imem_waddr, 32'h0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_wcnt", word_cnt, 0);
    chk("arst_hold", cpu_hold, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run_load(3, 1'b0);

    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(0, 9);
      fill_img(n);
      bad = CSUM_ON ? 1'($urandom_range(0, 1)) : 1'b0;
      gap_max = $urandom_range(0, 3);
      run_load(n, bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
